// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline register with a 2-entry skid buffer, flush/hold and bubble value.
// Optional performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_skid #(
    parameter int unsigned       DATA_W        = 32,
    parameter logic [DATA_W-1:0] DEFAULT_VALUE = {DATA_W{1'b0}}
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int unsigned       CNT_W         = 16
`endif
) (
    input  logic              sys_clk,
    input  logic              sys_arstn,
    input  logic              flag_flush,
    input  logic              flag_hold,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_stall_cnt,
    output logic [CNT_W-1:0]  perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

    logic              main_valid_q, main_valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    state_e            state;
    logic              acc, emt;

    // Occupancy is fully described by the two valid bits; skid never valid alone.
    always_comb begin
        state = EMPTY;
        if (main_valid_q) begin
            state = skid_valid_q ? FULL : ONE;
        end
    end

    assign in_ready  = !skid_valid_q && !flag_hold;
    assign out_valid = main_valid_q && !flag_hold;
    assign data_out  = out_valid ? main_data_q : DEFAULT_VALUE;
    assign acc       = in_valid && in_ready;
    assign emt       = out_valid && out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        if (flag_flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            main_data_d  = DEFAULT_VALUE;
            skid_data_d  = DEFAULT_VALUE;
        end else begin
            // Hold needs no branch: it forces acc and emt low, which keeps every state.
            case (state)
                EMPTY: begin
                    if (acc) begin
                        main_valid_d = 1'b1;
                        main_data_d  = data_in;
                    end
                end
                ONE: begin
                    if (acc && !emt) begin
                        skid_valid_d = 1'b1;
                        skid_data_d  = data_in;
                    end else if (acc && emt) begin
                        main_data_d  = data_in;
                    end else if (emt) begin
                        main_valid_d = 1'b0;
                    end
                end
                FULL: begin
                    if (emt) begin
                        main_data_d  = skid_data_q;
                        skid_valid_d = 1'b0;
                    end
                end
                default: begin
                    main_valid_d = 1'b0;
                    skid_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_arstn) begin
        if (!sys_arstn) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= DEFAULT_VALUE;
            skid_data_q  <= DEFAULT_VALUE;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Both counters saturate at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (out_valid && !out_ready && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flag_flush && (main_valid_q || skid_valid_q) && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_arstn) begin
        if (!sys_arstn) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid; perf checks active with PIPE_STAGE_PERF_EN.
module tb_pipe_stage_skid;

    localparam logic [31:0] DEF = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, hold, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] data_in, data_out;
    int          n_cmp = 0;
    int          n_fail = 0;
`ifdef PIPE_STAGE_PERF_EN
    logic [3:0]  stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .DATA_W        (32),
        .DEFAULT_VALUE (DEF)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .CNT_W         (4)
`endif
    ) dut (
        .sys_clk        (clk),
        .sys_arstn      (rst_n),
        .flag_flush     (flush),
        .flag_hold      (hold),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .data_in        (data_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .data_out       (data_out)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .perf_stall_cnt (stall_cnt),
        .perf_flush_cnt (flush_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 0; hold = 0; out_ready = 0;
        in_valid = 1'b1; data_in = 32'h123;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        n_cmp++; if (data_out !== DEF) begin n_fail++; $display("FAIL rst_data_out got=%h want=%h", data_out, DEF); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
`ifdef PIPE_STAGE_PERF_EN
        n_cmp++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_counters got=%0d/%0d want=0/0", stall_cnt, flush_cnt); end
`endif
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_release_empty got=%b want=0", out_valid); end
        $display("test_reset done");
    endtask

    task automatic test_streaming();
        step();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; data_in = 32'(i);
            @(negedge clk);
            n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d] got=%b want=1", i, in_ready); end
            n_cmp++; if (out_valid !== (i > 1) || data_out !== ((i > 1) ? 32'(i - 1) : DEF)) begin
                n_fail++; $display("FAIL stream_out[%0d] got=%b/%h want=%b/%h", i, out_valid, data_out, (i > 1), (i > 1) ? 32'(i - 1) : DEF);
            end
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || data_out !== 32'h8) begin n_fail++; $display("FAIL stream_last got=%b/%h want=1/00000008", out_valid, data_out); end
        step();
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0 || data_out !== DEF) begin n_fail++; $display("FAIL stream_drained got=%b/%h want=0/%h", out_valid, data_out, DEF); end
        $display("test_streaming done");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; data_in = 32'hA;
        step();
        data_in = 32'hB;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1 || data_out !== 32'hA) begin n_fail++; $display("FAIL bp_one got=%b/%h want=1/0000000a", in_ready, data_out); end
        step();
        data_in = 32'h77;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_in_ready got=%b want=0", in_ready); end
        n_cmp++; if (out_valid !== 1'b1 || data_out !== 32'hA) begin n_fail++; $display("FAIL bp_full_out got=%b/%h want=1/0000000a", out_valid, data_out); end
        step();
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || data_out !== 32'hA) begin n_fail++; $display("FAIL bp_first got=%b/%h want=1/0000000a", out_valid, data_out); end
        step();
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || data_out !== 32'hB || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_second got=%b/%h/%b want=1/0000000b/1", out_valid, data_out, in_ready); end
        step();
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup got=%b/%h want=0", out_valid, data_out); end
`ifdef PIPE_STAGE_PERF_EN
        n_cmp++; if (stall_cnt !== 4'd2) begin n_fail++; $display("FAIL bp_stall_cnt got=%0d want=2", stall_cnt); end
`endif
        $display("test_backpressure done");
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; data_in = 32'h1A;
        step();
        data_in = 32'h1B;
        step();
        flush = 1'b1; data_in = 32'hC;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0 || data_out !== DEF) begin n_fail++; $display("FAIL flush_out got=%b/%h want=0/%h", out_valid, data_out, DEF); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got=%b want=1", in_ready); end
        step();
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_c_leaked got=%b/%h want=0", out_valid, data_out); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
`ifdef PIPE_STAGE_PERF_EN
        n_cmp++; if (flush_cnt !== 4'd1) begin n_fail++; $display("FAIL flush_cnt got=%0d want=1", flush_cnt); end
        n_cmp++; if (stall_cnt !== 4'd4) begin n_fail++; $display("FAIL flush_stall_cnt got=%0d want=4", stall_cnt); end
`endif
        $display("test_flush done");
    endtask

    task automatic test_hold();
        out_ready = 1'b1;
        in_valid = 1'b1; data_in = 32'hD;
        step();
        hold = 1'b1; data_in = 32'hE;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || data_out !== DEF) begin
                n_fail++; $display("FAIL hold[%0d] got=%b/%b/%h want=0/0/%h", i, out_valid, in_ready, data_out, DEF);
            end
            step();
        end
        hold = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || data_out !== 32'hD) begin n_fail++; $display("FAIL hold_release got=%b/%h want=1/0000000d", out_valid, data_out); end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || data_out !== 32'hE) begin n_fail++; $display("FAIL hold_once got=%b/%h want=1/0000000e", out_valid, data_out); end
        step();
        in_valid = 1'b1; data_in = 32'hF;
        step();
        in_valid = 1'b0; hold = 1'b1; flush = 1'b1;
        step();
        hold = 1'b0; flush = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || data_out !== DEF) begin
            n_fail++; $display("FAIL flush_hold got=%b/%b/%h want=0/1/%h", out_valid, in_ready, data_out, DEF);
        end
`ifdef PIPE_STAGE_PERF_EN
        n_cmp++; if (flush_cnt !== 4'd2) begin n_fail++; $display("FAIL flush_hold_cnt got=%0d want=2", flush_cnt); end
`endif
        $display("test_hold done");
    endtask

    task automatic test_perf_saturation();
        out_ready = 1'b0;
        in_valid = 1'b1; data_in = 32'h66;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || data_out !== 32'h66) begin n_fail++; $display("FAIL sat_out got=%b/%h want=1/00000066", out_valid, data_out); end
`ifdef PIPE_STAGE_PERF_EN
        n_cmp++; if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_stall_cnt got=%0d want=15", stall_cnt); end
`endif
        out_ready = 1'b1;
        step();
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sat_drain got=%b want=0", out_valid); end
        $display("test_perf_saturation done");
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; data_in = 32'h99;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || data_out !== 32'h99) begin n_fail++; $display("FAIL areset_pre got=%b/%h want=1/00000099", out_valid, data_out); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || data_out !== DEF || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL areset_now got=%b/%h/%b want=0/%h/1", out_valid, data_out, in_ready, DEF);
        end
`ifdef PIPE_STAGE_PERF_EN
        n_cmp++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin n_fail++; $display("FAIL areset_counters got=%0d/%0d want=0/0", stall_cnt, flush_cnt); end
`endif
        step();
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_release got=%b want=0", out_valid); end
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_hold();
        test_perf_saturation();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
